jtvigil_rom_arb: RTL and testbench

- Parametrised successor to the fixed-slot ROM fetch logic used by the game top level.
- Serves SLOTS independent read-only ROM requesters from a single SDRAM bank port, with round-robin arbitration.
- Each slot has a one-entry cache holding its last fetched data, tagged by slot address.
- Sits between the CPU and video ROM clients and one ba_* bank channel of the SDRAM controller.

---
 rtl/jtvigil_rom_pkg.sv | 33 +++
 rtl/jtvigil_rom_rr.sv | 30 +++
 rtl/jtvigil_rom_arb.sv | 170 +++++++++++++++++
 tb/tb_jtvigil_rom_arb.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jtvigil_rom_pkg.sv
// Shared types and helpers for the jtvigil ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package jtvigil_rom_pkg;

  // SDRAM bank channel widths
  localparam int BA_AW = 22;
  localparam int BA_DW = 16;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2
  } rom_state_t;

  // Map a slot address to an SDRAM word address. Byte slots pack two entries
  // per word, 32-bit slots span two consecutive words. Sum wraps at 22 bits.
  function automatic logic [BA_AW-1:0] rom_word_addr(
    input logic [BA_AW-1:0] base,
    input logic [BA_AW-1:0] addr,
    input int               dw
  );
    logic [BA_AW-1:0] w;
    case (dw)
      8:       w = addr >> 1;
      32:      w = addr << 1;
      default: w = addr;
    endcase
    return base + w;
  endfunction

endpackage

// File: rtl/jtvigil_rom_rr.sv
// Round-robin picker: first set request bit strictly after ptr, wrapping.
// Latency: combinational.
// Backpressure: none; the caller decides when to accept the grant.
module jtvigil_rom_rr #(
  parameter int SLOTS = 4,
  parameter int PW    = 2
) (
  input  logic [SLOTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    gnt,
  output logic             any
);

  logic [PW-1:0] idx;

  // Scan ptr+1 .. ptr+SLOTS (mod SLOTS); the slot at ptr is checked last
  always_comb begin
    gnt = '0;
    any = 1'b0;
    idx = '0;
    for (int i = 1; i <= SLOTS; i++) begin
      idx = PW'((int'(ptr) + i) % SLOTS);
      if (!any && req[idx]) begin
        any = 1'b1;
        gnt = idx;
      end
    end
  end

endmodule

// File: rtl/jtvigil_rom_arb.sv
// Multi-slot ROM fetch arbiter: per-slot one-entry cache, round-robin SDRAM fetch.
// Latency: hit gives ok same cycle; miss = 1 cycle to ba_rd + SDRAM latency + 1 cycle after ba_rdy.
// Backpressure: ba_rd/ba_addr held until ba_ack; one burst outstanding; slots wait while not ok.
module jtvigil_rom_arb
  import jtvigil_rom_pkg::*;
#(
  parameter int                 SLOTS  = 4,
  parameter int                 AW     = 18,
  parameter int                 DW     = 8,
  parameter logic [SLOTS*22-1:0] OFFSET = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [SLOTS-1:0]       slot_cs,
  input  logic [SLOTS*AW-1:0]    slot_addr,
  output logic [SLOTS*DW-1:0]    slot_data,
  output logic [SLOTS-1:0]       slot_ok,
  input  logic                   downloading,
  output logic [BA_AW-1:0]       ba_addr,
  output logic                   ba_rd,
  input  logic                   ba_ack,
  input  logic                   ba_dst,
  input  logic                   ba_dok,
  input  logic                   ba_rdy,
  input  logic [BA_DW-1:0]       data_read
);

  localparam int PW = $clog2(SLOTS);

  rom_state_t       state, state_nxt;
  logic [PW-1:0]    ptr;
  logic [PW-1:0]    gnt_idx;
  logic [PW-1:0]    rr_gnt;
  logic             rr_any;
  logic [AW-1:0]    tag_lat;
  logic             wsel;
  logic             abort;
  logic             grant;
  logic             fill;
  logic [SLOTS-1:0] valid;
  logic [SLOTS-1:0] hit;
  logic [SLOTS-1:0] pending;
  logic [AW-1:0]    tag      [SLOTS];
  logic [DW-1:0]    data     [SLOTS];
  logic [AW-1:0]    addr_arr [SLOTS];
  logic [BA_AW-1:0] off_arr  [SLOTS];
  logic [DW-1:0]    data_new;

  // ba_dst only marks the first beat; wsel is only consumed by 32-bit slots
  wire unused_sink = &{1'b0, ba_dst, wsel};

  // Unpack slot buses and evaluate cache hits; ok is a pure function of current inputs
  always_comb begin
    hit       = '0;
    pending   = '0;
    slot_ok   = '0;
    slot_data = '0;
    for (int i = 0; i < SLOTS; i++) begin
      addr_arr[i]            = slot_addr[i*AW +: AW];
      off_arr[i]             = OFFSET[i*BA_AW +: BA_AW];
      hit[i]                 = valid[i] && (tag[i] == addr_arr[i]);
      slot_ok[i]             = slot_cs[i] & hit[i] & ~downloading;
      pending[i]             = slot_cs[i] & ~hit[i];
      slot_data[i*DW +: DW]  = data[i];
    end
  end

  jtvigil_rom_rr #(
    .SLOTS (SLOTS),
    .PW    (PW)
  ) u_rr (
    .req (pending),
    .ptr (ptr),
    .gnt (rr_gnt),
    .any (rr_any)
  );

  // Merge the incoming SDRAM word into the granted slot's data register
  generate
    if (DW == 8) begin : g_dw8
      always_comb data_new = tag_lat[0] ? data_read[15:8] : data_read[7:0];
    end else if (DW == 16) begin : g_dw16
      always_comb data_new = data_read;
    end else begin : g_dw32
      always_comb data_new = wsel ? {data_read, data[gnt_idx][15:0]}
                                  : {data[gnt_idx][31:16], data_read};
    end
  endgenerate

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and bus strobes; ba_rd is decoded straight from the REQ state
  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fill      = 1'b0;
    ba_rd     = 1'b0;
    case (state)
      IDLE: begin
        if (!downloading && rr_any) begin
          grant     = 1'b1;
          state_nxt = REQ;
        end
      end
      REQ: begin
        ba_rd = 1'b1;
        if (ba_ack) state_nxt = DATA;
      end
      DATA: begin
        if (ba_rdy) begin
          fill      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture slot index, tag and word address at grant so they stay stable on the bus
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_idx <= '0;
      tag_lat <= '0;
      ba_addr <= '0;
    end else if (grant) begin
      gnt_idx <= rr_gnt;
      tag_lat <= addr_arr[rr_gnt];
      ba_addr <= rom_word_addr(off_arr[rr_gnt], BA_AW'(addr_arr[rr_gnt]), DW);
    end
  end

  // Cache contents, valid bits and rotation pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
      ptr   <= '0;
      wsel  <= 1'b0;
      abort <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        tag[i]  <= '0;
        data[i] <= '0;
      end
    end else begin
      if (grant) begin
        wsel  <= 1'b0;
        abort <= 1'b0;
      end
      // A load that starts mid-burst poisons the fetch even if it ends before ba_rdy
      if (downloading && state != IDLE) abort <= 1'b1;
      if (state == DATA && ba_dok) begin
        data[gnt_idx] <= data_new;
        wsel          <= 1'b1;
      end
      if (fill) begin
        ptr <= gnt_idx;
        if (!abort && !downloading) begin
          valid[gnt_idx] <= 1'b1;
          tag[gnt_idx]   <= tag_lat;
        end
      end
      // ROM contents are changing: nothing cached can be trusted
      if (downloading) valid <= '0;
    end
  end

endmodule

// File: tb/tb_jtvigil_rom_arb.sv
// Self-checking bench for jtvigil_rom_arb: directed scenarios plus randomized
// cache/arbitration rounds checked against a transaction-level model.
// Two DUTs (DW=8 and DW=32) share the SDRAM responder; only one is active at a time.
module tb_jtvigil_rom_arb;

  localparam int SLOTS = 4;
  localparam int AW    = 18;
  localparam logic [SLOTS*22-1:0] OFF8  = {22'h30000, 22'h20000, 22'h10000, 22'h00000};
  localparam logic [SLOTS*22-1:0] OFF32 = {22'h3C000, 22'h2C000, 22'h1C000, 22'h00000};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, dl, ack, dst, dok, rdy;
  logic [15:0] dr;

  logic [SLOTS-1:0]    cs8, ok8, cs32, ok32;
  logic [SLOTS*AW-1:0] addr8, addr32;
  logic [SLOTS*8-1:0]  data8;
  logic [SLOTS*32-1:0] data32;
  logic [21:0]         a8, a32;
  logic                rd8, rd32;

  logic        sel;
  logic        cur_rd;
  logic [21:0] cur_addr;
  logic [3:0]  cur_ok;
  assign cur_rd   = sel ? rd32 : rd8;
  assign cur_addr = sel ? a32 : a8;
  assign cur_ok   = sel ? ok32 : ok8;

  jtvigil_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(8), .OFFSET(OFF8)) dut8 (
    .clk(clk), .rst(rst), .slot_cs(cs8), .slot_addr(addr8), .slot_data(data8),
    .slot_ok(ok8), .downloading(dl), .ba_addr(a8), .ba_rd(rd8), .ba_ack(ack),
    .ba_dst(dst), .ba_dok(dok), .ba_rdy(rdy), .data_read(dr)
  );

  jtvigil_rom_arb #(.SLOTS(SLOTS), .AW(AW), .DW(32), .OFFSET(OFF32)) dut32 (
    .clk(clk), .rst(rst), .slot_cs(cs32), .slot_addr(addr32), .slot_data(data32),
    .slot_ok(ok32), .downloading(dl), .ba_addr(a32), .ba_rd(rd32), .ba_ack(ack),
    .ba_dst(dst), .ba_dok(dok), .ba_rdy(rdy), .data_read(dr)
  );

  int errors = 0;
  int checks = 0;

  logic [21:0] off8  [4] = '{22'h00000, 22'h10000, 22'h20000, 22'h30000};
  logic [21:0] off32 [4] = '{22'h00000, 22'h1C000, 22'h2C000, 22'h3C000};

  // Reference model state (DW=8 instance)
  logic        mv   [4];
  logic [17:0] mtag [4];
  logic [7:0]  mdat [4];
  int          mptr;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] mem(input logic [21:0] a);
    return {a[7:0] ^ 8'h3C, a[15:8] ^ a[7:0] ^ 8'hA5};
  endfunction

  task automatic do_reset();
    rst = 1'b1; cs8 = '0; cs32 = '0; dl = 1'b0;
    ack = 1'b0; dok = 1'b0; rdy = 1'b0; dst = 1'b0; dr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_rd(input string tag);
    bit got;
    got = 1'b0;
    for (int n = 0; n < 40 && !got; n++) begin
      @(negedge clk);
      if (cur_rd === 1'b1) got = 1'b1;
    end
    check(tag, 64'(got), 64'd1);
  endtask

  task automatic no_rd(input string tag, input int cycles);
    int cnt;
    cnt = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (cur_rd !== 1'b0) cnt++;
    end
    check(tag, 64'(cnt), 64'd0);
  endtask

  // Hold off ack for la cycles; ba_rd and ba_addr must not move meanwhile
  task automatic serve_ack(input int la);
    logic [21:0] a0;
    int bad;
    a0 = cur_addr;
    bad = 0;
    repeat (la) begin
      @(negedge clk);
      if (cur_rd !== 1'b1 || cur_addr !== a0) bad++;
    end
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    check("req_hold", 64'(bad), 64'd0);
    check("rd_drop", 64'(cur_rd), 64'd0);
  endtask

  // Data beats then ba_rdy; ok_pre is slot_ok while ba_rdy is on the bus
  task automatic serve_data(input int ld, input logic [15:0] w0, input logic [15:0] w1,
                            input bit two, output logic [3:0] ok_pre);
    repeat (ld) @(negedge clk);
    dst = 1'b1; dok = 1'b1; dr = w0;
    @(negedge clk);
    dst = 1'b0;
    if (two) begin
      dr = w1;
      @(negedge clk);
    end
    dok = 1'b0; rdy = 1'b1;
    ok_pre = cur_ok;
    @(negedge clk);
    rdy = 1'b0; dr = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0]  okp;
    logic [17:0] ra [4];
    logic [3:0]  pend;
    int          g, guard;
    logic [21:0] wa;
    logic [15:0] w;

    sel = 1'b0; addr8 = '0; addr32 = '0;
    do_reset();

    // Reset state
    rst = 1'b1;
    @(negedge clk);
    check("rst_rd8",    64'(rd8),  64'd0);
    check("rst_addr8",  64'(a8),   64'd0);
    check("rst_ok8",    64'(ok8),  64'd0);
    check("rst_data8",  64'(data8), 64'd0);
    check("rst_rd32",   64'(rd32), 64'd0);
    check("rst_data32", data32[63:0] | data32[127:64], 64'd0);
    rst = 1'b0;

    // DW=8 slot 1 miss: word 0x10001, upper lane
    addr8[1*AW +: AW] = 18'h00003;
    cs8 = 4'b0010;
    wait_rd("t1_rd");
    check("t1_addr", 64'(cur_addr), 64'h10001);
    serve_ack(2);
    serve_data(1, 16'hA55A, 16'h0, 1'b0, okp);
    check("t1_ok_pre", 64'(okp[1]), 64'd0);
    check("t1_ok", 64'(ok8), 64'b0010);
    check("t1_data", 64'(data8[15:8]), 64'hA5);

    // Re-request same address: hit in the same cycle, no bus traffic
    cs8 = 4'b0000;
    #1 check("t2_ok_off", 64'(ok8), 64'd0);
    @(negedge clk);
    cs8 = 4'b0010;
    #1 check("t2_ok_hit", 64'(ok8), 64'b0010);
    no_rd("t2_no_rd", 6);

    // All four slots miss from ptr=0: order 1,2,3,0
    do_reset();
    for (int i = 0; i < 4; i++) addr8[i*AW +: AW] = 18'(18'h100 * i + 18'h21);
    cs8 = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      g = (k + 1) % 4;
      wait_rd("t4_rd");
      check("t4_addr", 64'(cur_addr), 64'(off8[g] + 22'(18'(18'h100 * g + 18'h21) >> 1)));
      serve_ack(k);
      serve_data(0, 16'(16'h1100 * (g + 1)), 16'h0, 1'b0, okp);
    end
    no_rd("t4_four_pulses", 10);
    check("t4_ok_all", 64'(ok8), 64'b1111);

    // Slot 2 address moves during DATA: old tag filled, refetch follows
    cs8 = 4'b0100;
    addr8[2*AW +: AW] = 18'h00100;
    wait_rd("t5_rd");
    check("t5_addr", 64'(cur_addr), 64'h20080);
    serve_ack(1);
    addr8[2*AW +: AW] = 18'h00101;
    serve_data(1, 16'h1234, 16'h0, 1'b0, okp);
    check("t5_ok_stale", 64'(ok8), 64'd0);
    wait_rd("t5_rd2");
    check("t5_addr2", 64'(cur_addr), 64'h20080);
    serve_ack(0);
    serve_data(0, 16'hBEEF, 16'h0, 1'b0, okp);
    check("t5_ok", 64'(ok8), 64'b0100);
    check("t5_data", 64'(data8[23:16]), 64'hBE);

    // downloading during DATA: ok drops, burst completes, no new fetch
    cs8 = 4'b1100;
    addr8[3*AW +: AW] = 18'h00005;
    wait_rd("t6_rd");
    check("t6_addr", 64'(cur_addr), 64'h30002);
    serve_ack(1);
    dl = 1'b1;
    #1 check("t6_ok_dl", 64'(ok8), 64'd0);
    serve_data(1, 16'h7E11, 16'h0, 1'b0, okp);
    check("t6_ok_after", 64'(ok8), 64'd0);
    no_rd("t6_dl_block", 8);
    cs8 = 4'b0000;
    dl = 1'b0;
    @(negedge clk);
    cs8 = 4'b1000;
    wait_rd("t6_rd2");
    check("t6_addr2", 64'(cur_addr), 64'h30002);
    serve_ack(0);
    serve_data(0, 16'h7E11, 16'h0, 1'b0, okp);
    check("t6_ok3", 64'(ok8), 64'b1000);
    check("t6_data3", 64'(data8[31:24]), 64'h7E);
    cs8 = 4'b1100;
    #1 check("t6_slot2_cleared", 64'(ok8), 64'b1000);

    // Reset while slot 2 is in REQ
    wait_rd("t7_rd");
    check("t7_addr", 64'(cur_addr), 64'h20080);
    rst = 1'b1;
    @(negedge clk);
    check("t7_rd_low", 64'(rd8), 64'd0);
    check("t7_valid_clr", 64'(ok8), 64'd0);
    cs8 = 4'b0000;
    rst = 1'b0;
    @(negedge clk);
    dok = 1'b1; rdy = 1'b1; dr = 16'hFFFF;
    @(negedge clk);
    dok = 1'b0; rdy = 1'b0; dr = '0;
    cs8 = 4'b1000;
    #1 check("t7_late_ignored", 64'(ok8), 64'd0);

    // DW=32: two words per entry
    do_reset();
    sel = 1'b1;
    addr32[0 +: AW] = 18'h00010;
    cs32 = 4'b0001;
    wait_rd("t3_rd");
    check("t3_addr", 64'(cur_addr), 64'h00020);
    serve_ack(1);
    serve_data(0, 16'h1234, 16'h5678, 1'b1, okp);
    check("t3_ok", 64'(ok32), 64'b0001);
    check("t3_data", 64'(data32[31:0]), 64'h56781234);

    // DW=32 with ba_rdy before the second beat: still valid
    addr32[1*AW +: AW] = 18'h00007;
    cs32 = 4'b0011;
    wait_rd("t8_rd");
    check("t8_addr", 64'(cur_addr), 64'(22'h1C000 + 22'h0000E));
    serve_ack(0);
    serve_data(2, 16'hAAAA, 16'h0, 1'b0, okp);
    check("t8_ok", 64'(ok32), 64'b0011);
    check("t8_data", 64'(data32[63:32]), 64'h0000AAAA);

    // Randomized rounds on the DW=8 instance against the cache model
    do_reset();
    sel = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mv[i] = 1'b0; mtag[i] = '0; mdat[i] = '0;
    end
    mptr = 0;
    for (int r = 0; r < 40; r++) begin
      if (r % 9 == 4) begin
        dl = 1'b1;
        repeat (2) @(negedge clk);
        dl = 1'b0;
        for (int i = 0; i < 4; i++) mv[i] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        cs8[i] = ($urandom_range(0, 3) != 0);
        ra[i]  = 18'($urandom_range(0, 7));
        addr8[i*AW +: AW] = ra[i];
      end
      guard = 0;
      pend = 4'b1111;
      while (pend != 0 && guard < 6) begin
        guard++;
        for (int i = 0; i < 4; i++) pend[i] = cs8[i] && !(mv[i] && mtag[i] == ra[i]);
        if (pend != 0) begin
          g = -1;
          for (int k = 1; k <= 4; k++)
            if (g < 0 && pend[(mptr + k) % 4]) g = (mptr + k) % 4;
          wa = off8[g] + 22'(ra[g] >> 1);
          w  = mem(wa);
          wait_rd("rnd_rd");
          check("rnd_addr", 64'(cur_addr), 64'(wa));
          serve_ack($urandom_range(0, 3));
          serve_data($urandom_range(0, 3), w, 16'h0, 1'b0, okp);
          mv[g]   = 1'b1;
          mtag[g] = ra[g];
          mdat[g] = ra[g][0] ? w[15:8] : w[7:0];
          mptr    = g;
        end
      end
      no_rd("rnd_idle", 4);
      for (int i = 0; i < 4; i++) pend[i] = cs8[i] && mv[i] && mtag[i] == ra[i];
      check("rnd_ok", 64'(ok8), 64'(pend));
      check("rnd_data", 64'(data8), 64'({mdat[3], mdat[2], mdat[1], mdat[0]}));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
